ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
// - RV32M multiply/divide engine in the EX stage. Consumes the operands produced by the EX operand
//   muxes (after forwarding has selected ID/EX, EX/MEM or MEM/WB data). Executes all eight M-extension ops.
// - Multiply: 2 cycles. Divide/remainder: iterative radix-2, DATA_WIDTH+1 cycles.
// - Holds the front of the pipeline through stall until the result is ready for EX/MEM.
// PARAMETERS
// - DATA_WIDTH  32  operand/result width; iteration counter is $clog2(DATA_WIDTH)+1 bits
// - REG_ID_W     5  register index width
// PORTS
// - clk         in   1           pipeline clock
// - reset       in   1           synchronous, active-high
// - start       in   1           ID/EX holds a valid M-op (opcode OP, funct7=0000001)
// - flush       in   1           kill in-flight op (branch mispredict / trap)
// - funct3      in   3           000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
// - op_a        in   DATA_WIDTH  forwarded rs1 value
// - op_b        in   DATA_WIDTH  forwarded rs2 value
// - rd_id       in   REG_ID_W    destination register of the op
// - stall       out  1           freeze PC, IF/ID, ID/EX; insert bubble into EX/MEM
// - done        out  1           result/rd_id_out valid this cycle (1-cycle pulse)
// - result      out  DATA_WIDTH  registered result
// - rd_id_out   out  REG_ID_W    registered destination of result
// BEHAVIOUR
// - FSM states: IDLE, MUL, DIV, DONE. All regs update on posedge clk only.
// - Reset: state=IDLE; done=0; result=0; rd_id_out=0; counter=0; internal remainder/quotient=0.
// - IDLE & start: latch op_a, op_b, funct3, rd_id. Go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
// - stall (combinational) = (IDLE & start) | state==MUL | state==DIV. It is 0 in DONE.
//   EX/MEM therefore captures the instruction in the DONE cycle.
// - start seen in DONE is the same instruction: ignore it, return to IDLE.
//   A start in the cycle after DONE is a new op.
// - MUL: form the 2*DATA_WIDTH product in one cycle.
//   - MUL: a,b either signedness, low half.
//   - MULH: signed x signed, high half. MULHSU: signed a x unsigned b, high half. MULHU: unsigned x unsigned, high half.
//   - Register the selected half into result. Next state DONE.
// - DIV: signed ops take magnitudes and record the sign of the quotient (sa^sb) and remainder (sa).
//   - Restoring shift-subtract, one quotient bit per cycle, DATA_WIDTH cycles.
//   - Then one fixup cycle applies the signs and selects quotient or remainder. Next state DONE.
// - Latency, start accepted at cycle t: MUL done=1 at t+2; DIV/REM done=1 at t+DATA_WIDTH+2 (t+34).
// - DONE: done=1, result and rd_id_out stable. Next state IDLE.
// - Divide by zero: DIV/DIVU gives all-ones; REM/REMU gives op_a.
// - Signed overflow, op_a=0x80000000 and op_b=-1: DIV gives 0x80000000; REM gives 0.
// - rd_id=0: op executes normally. Write suppression to x0 is the regfile's job.
// - flush (priority over start, any state): next state IDLE; done forced 0 next cycle; result unchanged.
//   - flush & start in IDLE: op is not accepted.
// - reset has priority over flush. Reset mid-op returns to IDLE with no done pulse.
// CONFIGURATION
// - MULDIV_EARLY_OUT_EN defined: divide-by-zero and signed overflow are detected in IDLE at accept.
//   The architectural result is loaded directly and the FSM goes to DONE next cycle (done at t+1).
//   stall is asserted only in the accept cycle.
// - Undefined: those cases take the full DIV path. Same results, same t+34 latency. No detection logic.
// TESTING
// - MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, done exactly at t+2, stall high t..t+1.
// - MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//   MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
// - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14.
//   All complete with done at t+34.
// - DIVU 0x1234/0 -> 0xFFFFFFFF. REMU 0x1234/0 -> 0x1234. DIV 0x80000000/-1 -> 0x80000000.
//   REM same operands -> 0.
//   Latency t+34 without MULDIV_EARLY_OUT_EN, t+1 with it.
// - flush at t+10 of a DIV -> IDLE at t+11, no done pulse. A MUL started at t+12 -> done t+14,
//   correct result. Reset mid-MUL -> no done, outputs zero.
// - Back-to-back MUL then DIV, start held high through DONE -> exactly two done pulses.
//   rd_id_out matches each op.

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit_if
// Description : EX-stage multiply/divide handshake and result bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_muldiv_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ID_W   = 5
) ();
  logic                  start;
  logic                  flush;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [REG_ID_W-1:0]   rd_id;
  logic                  stall;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  logic [REG_ID_W-1:0]   rd_id_out;

  modport master (
    output start, flush, funct3, op_a, op_b, rd_id,
    input  stall, done, result, rd_id_out
  );

  modport slave (
    input  start, flush, funct3, op_a, op_b, rd_id,
    output stall, done, result, rd_id_out
  );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit
// Description : RV32M multiply (2 cycles) / radix-2 restoring divide
//               (DATA_WIDTH+2 cycles) engine for the EX stage.
//               Optional macro MULDIV_EARLY_OUT_EN: resolve divide-by-zero and
//               signed overflow at accept time (done one cycle later).
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ID_W   = 5
) (
  input  wire logic         clk,
  input  wire logic         reset,
  ex_muldiv_unit_if.slave   bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] C_DIV_LAST = CNT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [1:0]            fn_q, fn_d;
  logic [REG_ID_W-1:0]   rd_q, rd_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [REG_ID_W-1:0]   rd_id_out_q, rd_id_out_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic                  q_neg_q, q_neg_d;
  logic                  r_neg_q, r_neg_d;

  logic                    w_a_neg;
  logic                    w_b_neg;
  logic [DATA_WIDTH-1:0]   w_mag_a;
  logic [DATA_WIDTH-1:0]   w_mag_b;
  logic                    w_a_signed;
  logic                    w_b_signed;
  logic [2*DATA_WIDTH-1:0] w_mul_a;
  logic [2*DATA_WIDTH-1:0] w_mul_b;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [DATA_WIDTH-1:0]   w_mul_res;
  logic [DATA_WIDTH:0]     w_rem_sh;
  logic [DATA_WIDTH:0]     w_diff;
  logic                    w_q_bit;
  logic [DATA_WIDTH-1:0]   w_rem_next;
  logic [DATA_WIDTH-1:0]   w_q_fix;
  logic [DATA_WIDTH-1:0]   w_r_fix;

  // Signed divide variants are 100/110, i.e. funct3[0]==0.
  always_comb begin
    w_a_neg = bus.op_a[DATA_WIDTH-1] & ~bus.funct3[0];
    w_b_neg = bus.op_b[DATA_WIDTH-1] & ~bus.funct3[0];
    w_mag_a = w_a_neg ? (~bus.op_a + 1'b1) : bus.op_a;
    w_mag_b = w_b_neg ? (~bus.op_b + 1'b1) : bus.op_b;
  end

  // Sign-extend to 2W bits; the 2W-bit wrapped product is exact for every mix.
  always_comb begin
    w_a_signed = (fn_q == 2'b01) | (fn_q == 2'b10);
    w_b_signed = (fn_q == 2'b01);
    w_mul_a    = {{DATA_WIDTH{w_a_signed & a_q[DATA_WIDTH-1]}}, a_q};
    w_mul_b    = {{DATA_WIDTH{w_b_signed & b_q[DATA_WIDTH-1]}}, b_q};
    w_prod     = w_mul_a * w_mul_b;
    w_mul_res  = (fn_q == 2'b00) ? w_prod[DATA_WIDTH-1:0]
                                 : w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
  end

  always_comb begin
    w_rem_sh   = {rem_q, quo_q[DATA_WIDTH-1]};
    w_diff     = w_rem_sh - {1'b0, dvs_q};
    w_q_bit    = ~w_diff[DATA_WIDTH];
    w_rem_next = w_q_bit ? w_diff[DATA_WIDTH-1:0] : w_rem_sh[DATA_WIDTH-1:0];
    // A zero divisor leaves an all-ones quotient, which must not be negated.
    w_q_fix    = (q_neg_q && (dvs_q != '0)) ? (~quo_q + 1'b1) : quo_q;
    w_r_fix    = r_neg_q ? (~rem_q + 1'b1) : rem_q;
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    fn_d        = fn_q;
    rd_d        = rd_q;
    result_d    = result_q;
    rd_id_out_d = rd_id_out_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;

    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_d     = bus.op_a;
            b_d     = bus.op_b;
            fn_d    = bus.funct3[1:0];
            rd_d    = bus.rd_id;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = w_mag_a;
            dvs_d   = w_mag_b;
            q_neg_d = w_a_neg ^ w_b_neg;
            r_neg_d = w_a_neg;
            state_d = bus.funct3[2] ? S_DIV : S_MUL;
`ifdef MULDIV_EARLY_OUT_EN
            if (bus.funct3[2]) begin
              if (bus.op_b == '0) begin
                result_d    = bus.funct3[1] ? bus.op_a : '1;
                rd_id_out_d = bus.rd_id;
                done_d      = 1'b1;
                state_d     = S_DONE;
              end else if (~bus.funct3[0]
                           && (bus.op_a == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                           && (bus.op_b == '1)) begin
                result_d    = bus.funct3[1] ? '0 : bus.op_a;
                rd_id_out_d = bus.rd_id;
                done_d      = 1'b1;
                state_d     = S_DONE;
              end
            end
`endif
          end
        end
        S_MUL: begin
          result_d    = w_mul_res;
          rd_id_out_d = rd_q;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end
        S_DIV: begin
          if (cnt_q == C_DIV_LAST) begin
            result_d    = fn_q[1] ? w_r_fix : w_q_fix;
            rd_id_out_d = rd_q;
            done_d      = 1'b1;
            state_d     = S_DONE;
          end else begin
            rem_d = w_rem_next;
            quo_d = {quo_q[DATA_WIDTH-2:0], w_q_bit};
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          // DONE: a start still asserted here belongs to the retiring op.
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      fn_q        <= '0;
      rd_q        <= '0;
      result_q    <= '0;
      rd_id_out_q <= '0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fn_q        <= fn_d;
      rd_q        <= rd_d;
      result_q    <= result_d;
      rd_id_out_q <= rd_id_out_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
    end
  end

  assign bus.stall     = ((state_q == S_IDLE) & bus.start)
                       | (state_q == S_MUL) | (state_q == S_DIV);
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.rd_id_out = rd_id_out_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv_unit
// Description : Scoreboard bench for ex_muldiv_unit with directed RV32M vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;

  localparam int W  = 32;
  localparam int RW = 5;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 34;
`endif

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.DATA_WIDTH(W), .REG_ID_W(RW)) ifc ();

  ex_muldiv_unit #(.DATA_WIDTH(W), .REG_ID_W(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  exp_t        sb_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_done = 0;
  logic [31:0] cyc    = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ifc.done === 1'b1) begin
      exp_t e;
      n_done++;
      if (sb_q.size() == 0) begin
        chk("done_unexpected", {31'b0, ifc.done}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("result", ifc.result, e.res);
        chk("rd_id_out", {27'b0, ifc.rd_id_out}, {27'b0, e.rd});
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      chk("timeout_pending", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    ifc.funct3 = f3;
    ifc.op_a   = a;
    ifc.op_b   = b;
    ifc.rd_id  = rd;
    ifc.start  = 1'b1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res, input int lat,
                       input bit mul_stall_chk);
    exp_t e;
    @(negedge clk);
    drive(f3, a, b, rd);
    #1;
    chk("stall_accept", {31'b0, ifc.stall}, 32'd1);
    e.res = exp_res;
    e.rd  = rd;
    e.cyc = cyc + lat;
    sb_q.push_back(e);
    @(negedge clk);
    ifc.start = 1'b0;
    if (mul_stall_chk) begin
      #1;
      chk("stall_mul_t1", {31'b0, ifc.stall}, 32'd1);
      @(negedge clk);
      #1;
      chk("stall_done_t2", {31'b0, ifc.stall}, 32'd0);
    end
    drain(60);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t0;
    int          d0;

    reset      = 1'b1;
    ifc.start  = 1'b0;
    ifc.flush  = 1'b0;
    ifc.funct3 = 3'b000;
    ifc.op_a   = '0;
    ifc.op_b   = '0;
    ifc.rd_id  = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_done", {31'b0, ifc.done}, 32'd0);
    chk("rst_result", ifc.result, 32'd0);
    chk("rst_rd_id_out", {27'b0, ifc.rd_id_out}, 32'd0);
    chk("rst_stall", {31'b0, ifc.stall}, 32'd0);
    reset = 1'b0;

    // Multiply family
    issue(3'b000, 32'd7,        32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 2, 1'b1);
    issue(3'b001, 32'h80000000, 32'h80000000, 5'd2, 32'h40000000, 2, 1'b0);
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, 2, 1'b0);
    issue(3'b010, 32'hFFFFFFFF, 32'd2,        5'd4, 32'hFFFFFFFF, 2, 1'b0);
    issue(3'b000, 32'd12345,    32'd0,        5'd0, 32'd0,        2, 1'b0);

    // Divide family
    issue(3'b100, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, 34, 1'b0);
    issue(3'b110, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 34, 1'b0);
    issue(3'b101, 32'd100,      32'd7, 5'd7, 32'd14,       34, 1'b0);
    issue(3'b111, 32'd100,      32'd7, 5'd8, 32'd2,        34, 1'b0);
    issue(3'b100, 32'd100,      32'hFFFFFFF9, 5'd9, 32'hFFFFFFF2, 34, 1'b0);

    // Divide-by-zero and signed overflow
    issue(3'b101, 32'h1234,     32'd0,        5'd10, 32'hFFFFFFFF, SPECIAL_LAT, 1'b0);
    issue(3'b111, 32'h1234,     32'd0,        5'd11, 32'h00001234, SPECIAL_LAT, 1'b0);
    issue(3'b100, 32'hFFFFFFFB, 32'd0,        5'd12, 32'hFFFFFFFF, SPECIAL_LAT, 1'b0);
    issue(3'b110, 32'hFFFFFFFB, 32'd0,        5'd13, 32'hFFFFFFFB, SPECIAL_LAT, 1'b0);
    issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, SPECIAL_LAT, 1'b0);
    issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h00000000, SPECIAL_LAT, 1'b0);

    // Flush at t+10 of a DIV, then a MUL started at t+12
    issue(3'b000, 32'd9, 32'd9, 5'd16, 32'd81, 2, 1'b0);
    @(negedge clk);
    drive(3'b101, 32'd1000, 32'd3, 5'd17);
    t0 = cyc;
    @(negedge clk);
    ifc.start = 1'b0;
    while (cyc < t0 + 10) @(negedge clk);
    ifc.flush = 1'b1;
    @(negedge clk);
    ifc.flush = 1'b0;
    #1;
    chk("flush_stall", {31'b0, ifc.stall}, 32'd0);
    chk("flush_done", {31'b0, ifc.done}, 32'd0);
    chk("flush_result_hold", ifc.result, 32'd81);
    issue(3'b000, 32'd6, 32'd5, 5'd18, 32'd30, 2, 1'b0);

    // flush together with start in IDLE: not accepted
    @(negedge clk);
    drive(3'b000, 32'd3, 32'd3, 5'd19);
    ifc.flush = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.flush = 1'b0;
    #1;
    chk("flush_start_stall", {31'b0, ifc.stall}, 32'd0);

    // Reset in the middle of a MUL
    @(negedge clk);
    drive(3'b000, 32'd11, 32'd11, 5'd20);
    @(negedge clk);
    ifc.start = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_done", {31'b0, ifc.done}, 32'd0);
    chk("midrst_result", ifc.result, 32'd0);
    chk("midrst_rd_id_out", {27'b0, ifc.rd_id_out}, 32'd0);
    @(negedge clk);
    #1;
    chk("midrst_done_late", {31'b0, ifc.done}, 32'd0);

    // Back-to-back MUL then DIV with start held through each DONE
    d0 = n_done;
    @(negedge clk);
    drive(3'b000, 32'd6, 32'd7, 5'd21);
    t0 = cyc;
    #1;
    sb_q.push_back('{res: 32'd42, rd: 5'd21, cyc: t0 + 2});
    while (cyc < t0 + 3) @(negedge clk);
    drive(3'b100, 32'd100, 32'd7, 5'd22);
    #1;
    sb_q.push_back('{res: 32'd14, rd: 5'd22, cyc: t0 + 3 + 34});
    while (cyc < t0 + 38) @(negedge clk);
    ifc.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("b2b_done_count", n_done - d0, 2);
    chk("b2b_pending", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
